// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble binary to BCD converter: one input bit per cycle,
// N packed output digits, sticky overflow when the value exceeds 10^N - 1.
module bin2bcd_seq #(
    parameter int W = 14,
    parameter int N = 4
) (
    input  logic           clk,
    input  logic           reset_n,
    input  logic           start,
    input  logic [W-1:0]   bin,
    output logic           ready,
    output logic           done_tick,
    output logic [4*N-1:0] bcd,
    output logic           ovf
);

    localparam int CW = $clog2(W + 1);
    localparam logic [CW-1:0] W_CNT = CW'(W);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_OP   = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]     state;
    logic [W-1:0]   sr;
    logic [4*N-1:0] dig;
    logic [4*N-1:0] dig_adj;
    logic [CW-1:0]  cnt;
    logic           ovf_sticky;

    // done_tick is registered, so the cycle it is high also blocks new starts
    assign ready = (state == S_IDLE) && !done_tick;

    always_comb begin
        dig_adj = dig;
        for (int i = 0; i < N; i++) begin
            if (dig[4*i +: 4] >= 4'd5)
                dig_adj[4*i +: 4] = dig[4*i +: 4] + 4'd3;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= S_IDLE;
            sr         <= '0;
            dig        <= '0;
            cnt        <= '0;
            ovf_sticky <= 1'b0;
            done_tick  <= 1'b0;
            bcd        <= '0;
            ovf        <= 1'b0;
        end else begin
            done_tick <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start && !done_tick) begin
                        sr         <= bin;
                        dig        <= '0;
                        cnt        <= W_CNT;
                        ovf_sticky <= 1'b0;
                        state      <= S_OP;
                    end
                end
                S_OP: begin
                    // the bit leaving the top digit is a lost multiple of 10^N
                    {dig, sr}  <= {dig_adj[4*N-2:0], sr, 1'b0};
                    ovf_sticky <= ovf_sticky | dig_adj[4*N-1];
                    cnt        <= cnt - CW'(1);
                    if (cnt == CW'(1))
                        state <= S_DONE;
                end
                S_DONE: begin
                    bcd       <= dig;
                    ovf       <= ovf_sticky;
                    done_tick <= 1'b1;
                    state     <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
